// File: rtl/hoplite_rt_pkg.sv
// hoplite_rt_pkg: shared defaults and types for the Hoplite real-time NoC
// client-side blocks (injection regulator, rate counter).
package hoplite_rt_pkg;

   // Default packet width (payload plus routing header, opaque here)
   localparam int D_W_DEF   = 32;
   // Default width of statistics counters
   localparam int CNT_W_DEF = 16;
   // Default injection FIFO depth
   localparam int DEPTH_DEF = 4;

   // Packet as carried on the PE injection port
   typedef logic [D_W_DEF-1:0] pkt_t;

   // Width needed to count 0..depth inclusive
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/inject_fifo.sv
// inject_fifo: small synchronous FIFO holding client packets ahead of the
// router injection port. Explicit occupancy counter, power-of-two depth,
// naturally wrapping pointers. The caller never pushes when full nor pops
// when empty, so nothing here guards against either.
module inject_fifo
   import hoplite_rt_pkg::*;
#(
   parameter int D_W   = D_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [D_W-1:0]             i_data,
   input  logic                       i_pop,
   output logic [D_W-1:0]             o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_occ,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = occ_width(DEPTH);

   logic [D_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [OCC_W-1:0] r_occ;

   // Storage write; contents need no reset since occupancy gates visibility
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   // Pointers and occupancy; reset discards everything buffered
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + PTR_W'(1);
         if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_occ   = r_occ;
   assign o_full  = (r_occ == OCC_W'(DEPTH));
   assign o_empty = (r_occ == '0);

endmodule

// File: rtl/inject_regulator.sv
// inject_regulator: client-side injection stage for the Hoplite real-time
// NoC. Buffers client packets, offers the head to the router only while the
// rate counter's token is high, and acks the counter once per accepted packet.
// Optional stall statistics under INJECT_REGULATOR_STATS_EN; when undefined
// the stat outputs are tied to zero and no counter flops exist.
module inject_regulator
   import hoplite_rt_pkg::*;
#(
   parameter int D_W   = D_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_v,
   input  logic [D_W-1:0]             in_data,
   output logic                       in_ready,
   input  logic                       token,
   output logic                       ack,
   output logic                       out_v,
   output logic [D_W-1:0]             out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           stall_token_cnt,
   output logic [CNT_W-1:0]           stall_net_cnt
);

   logic w_push;
   logic w_fire;
   logic w_full;
   logic w_empty;

   // in_ready depends only on registered occupancy: no path from out_ready,
   // and a full FIFO refuses a push even when a pop happens the same cycle.
   assign in_ready = !w_full;
   assign w_push   = in_v && in_ready;

   // Head offered only while a token is available; dropping the token
   // withdraws the request the same cycle without consuming the packet.
   assign out_v  = !w_empty && token;
   assign w_fire = out_v && out_ready;
   assign ack    = w_fire;

   inject_fifo #(
      .D_W   (D_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_push  (w_push),
      .i_data  (in_data),
      .i_pop   (w_fire),
      .o_head  (out_data),
      .o_occ   (occupancy),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

`ifdef INJECT_REGULATOR_STATS_EN
   logic [CNT_W-1:0] r_stall_tok;
   logic [CNT_W-1:0] r_stall_net;

   // Saturating stall counters: waiting on a token vs. blocked by the router
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_tok <= '0;
         r_stall_net <= '0;
      end else begin
         if (!w_empty && !token && (r_stall_tok != '1))
            r_stall_tok <= r_stall_tok + CNT_W'(1);
         if (!w_empty && token && !out_ready && (r_stall_net != '1))
            r_stall_net <= r_stall_net + CNT_W'(1);
      end
   end

   assign stall_token_cnt = r_stall_tok;
   assign stall_net_cnt   = r_stall_net;
`else
   assign stall_token_cnt = '0;
   assign stall_net_cnt   = '0;
`endif

endmodule
